// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: default vectors, fetch FSM states, target alignment.
// Pure declarations; no logic and no latency of its own.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DFLT = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DFLT    = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PENDING = 2'd1,
        HALTED  = 2'd2
    } ifetch_state_t;

    // Branch targets are always word addresses; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_skid.sv
// One-entry valid/ready holding register for fetched instructions; loads on i_cap_en.
// One cycle from capture to o_vld; holds its contents while o_vld && !i_rdy.
module ifetch_skid (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cap_en,
    input  logic [31:0] i_instr_dat,
    input  logic [31:0] i_pc_dat,
    input  logic        i_rdy,
    output logic        o_vld,
    output logic [31:0] o_instr_dat,
    output logic [31:0] o_pc_dat,
    output logic        o_free
);

    logic        r_vld;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld   <= 1'b0;
            r_instr <= 32'd0;
            r_pc    <= 32'd0;
        end else if (i_cap_en) begin
            r_vld   <= 1'b1;
            r_instr <= i_instr_dat;
            r_pc    <= i_pc_dat;
        end else if (r_vld && i_rdy) begin
            r_vld   <= 1'b0;
        end
    end

    // The slot can take a new word when empty or when its occupant leaves this cycle.
    assign o_free      = !r_vld || i_rdy;
    assign o_vld       = r_vld;
    assign o_instr_dat = r_instr;
    assign o_pc_dat    = r_pc;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: pc register, redirect/delay-slot FSM and halt detection over a combinational imem.
// Fetched word appears one cycle after its address; decode backpressure freezes pc and the held word.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DFLT,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        active
);

    ifetch_state_t r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_pending_target;
    logic          r_active;

    logic          w_free;
    logic          w_at_halt;
    logic          w_capture;
    logic [31:0]   w_target;
    logic [31:0]   w_next_pc;

    assign w_at_halt = (r_pc == HALT_ADDR);
    assign w_capture = (r_state != HALTED) && !w_at_halt && w_free;
    assign w_target  = word_align(redirect_target);

    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (r_state == PENDING) begin
            w_next_pc = r_pending_target;
        end else if (redirect_valid) begin
            w_next_pc = w_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= RUN;
            r_pc             <= RESET_VECTOR;
            r_pending_target <= 32'd0;
            r_active         <= 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_at_halt) begin
                        r_state  <= HALTED;
                        r_active <= 1'b0;
                    end else if (w_capture) begin
                        // A redirect taken here makes the word captured now the delay slot.
                        r_pc <= w_next_pc;
                    end else if (redirect_valid) begin
                        r_pending_target <= w_target;
                        r_state          <= PENDING;
                    end
                end
                PENDING: begin
                    // Further redirects are ignored: the delay slot cannot itself branch.
                    if (w_at_halt) begin
                        r_state  <= HALTED;
                        r_active <= 1'b0;
                    end else if (w_capture) begin
                        r_pc    <= w_next_pc;
                        r_state <= RUN;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state  <= HALTED;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    ifetch_skid u_skid (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_cap_en    (w_capture),
        .i_instr_dat (instr_readdata),
        .i_pc_dat    (r_pc),
        .i_rdy       (fetch_ready),
        .o_vld       (fetch_valid),
        .o_instr_dat (fetch_instr),
        .o_pc_dat    (fetch_pc),
        .o_free      (w_free)
    );

    assign instr_address = r_pc;
    assign active        = r_active;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboarded bench for ifetch_unit: expected fetch_pc stream queued by stimulus,
// popped on every decode handshake; directed checks cover reset, stall, redirect and halt.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        active;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    assign instr_readdata = mem_word(instr_address);

    ifetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_instr     (fetch_instr),
        .fetch_pc        (fetch_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .active          (active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [31:0] addr);
        int n = 0;
        while (!(fetch_valid && fetch_pc == addr) && n < 40) begin
            tick();
            n++;
        end
        check("wait_pc", fetch_pc, addr);
        check("wait_vld", fetch_valid, 1);
    endtask

    // Each accepted word must be the next queued address and the memory word for it.
    always @(negedge clk) begin
        if (reset && fetch_valid && fetch_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", exp_q.size(), 1);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", fetch_pc, e);
                check("sb_instr", fetch_instr, mem_word(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'd0;
        tick(); tick();
        check("rst_vld", fetch_valid, 0);
        check("rst_pc", fetch_pc, 32'd0);
        check("rst_instr", fetch_instr, 32'd0);
        check("rst_ia", instr_address, 32'hBFC0_0000);
        check("rst_active", active, 1);

        // Sequential fetch after release
        reset = 1'b1;
        exp_q.push_back(32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0004);
        tick();
        check("seq0_vld", fetch_valid, 1);
        check("seq0_pc", fetch_pc, 32'hBFC0_0000);
        check("seq0_ia", instr_address, 32'hBFC0_0004);
        tick();
        check("seq1_pc", fetch_pc, 32'hBFC0_0004);
        check("seq1_ia", instr_address, 32'hBFC0_0008);

        // Three-cycle decode stall
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", fetch_pc, 32'hBFC0_0004);
            check("stall_instr", fetch_instr, mem_word(32'hBFC0_0004));
            check("stall_ia", instr_address, 32'hBFC0_0008);
        end
        exp_q.push_back(32'hBFC0_0008);
        exp_q.push_back(32'hBFC0_000C);
        exp_q.push_back(32'hBFC0_0010);
        fetch_ready = 1'b1;

        // Branch accepted with capture: delay slot then aligned target
        wait_pc(32'hBFC0_0010);
        exp_q.push_back(32'hBFC0_0014);
        exp_q.push_back(32'hBFC0_0100);
        exp_q.push_back(32'hBFC0_0104);
        redirect_valid = 1'b1; redirect_target = 32'hBFC0_0103;
        tick();
        check("br_slot", fetch_pc, 32'hBFC0_0014);
        check("br_ia", instr_address, 32'hBFC0_0100);
        redirect_valid = 1'b0;
        tick();
        check("br_tgt", fetch_pc, 32'hBFC0_0100);

        // Redirect during a stall goes through PENDING; a second redirect is ignored
        wait_pc(32'hBFC0_0104);
        fetch_ready = 1'b0;
        exp_q.push_back(32'hBFC0_0108);
        exp_q.push_back(32'hBFC0_0200);
        exp_q.push_back(32'hBFC0_0204);
        tick();
        check("pend_ia0", instr_address, 32'hBFC0_0108);
        redirect_valid = 1'b1; redirect_target = 32'hBFC0_0200;
        tick();
        check("pend_pc", fetch_pc, 32'hBFC0_0104);
        check("pend_ia1", instr_address, 32'hBFC0_0108);
        redirect_target = 32'hBFC0_0300;
        tick();
        check("pend_ia2", instr_address, 32'hBFC0_0108);
        fetch_ready = 1'b1;
        tick();
        check("pend_slot", fetch_pc, 32'hBFC0_0108);
        check("pend_ia3", instr_address, 32'hBFC0_0200);
        redirect_valid = 1'b0;
        tick();
        check("pend_tgt", fetch_pc, 32'hBFC0_0200);

        // Jump to the halt address; held delay slot still completes in HALTED
        wait_pc(32'hBFC0_0204);
        exp_q.push_back(32'hBFC0_0208);
        redirect_valid = 1'b1; redirect_target = 32'h0000_0000;
        tick();
        check("jr_slot", fetch_pc, 32'hBFC0_0208);
        check("jr_ia", instr_address, 32'h0000_0000);
        check("jr_active", active, 1);
        redirect_valid = 1'b0; fetch_ready = 1'b0;
        tick();
        check("halt_active", active, 0);
        check("halt_held_vld", fetch_valid, 1);
        check("halt_held_pc", fetch_pc, 32'hBFC0_0208);
        fetch_ready = 1'b1;
        tick();
        check("halt_drained", fetch_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_vld", fetch_valid, 0);
            check("halt_act", active, 0);
            check("halt_ia", instr_address, 32'h0000_0000);
        end

        // One-cycle reset restarts at the reset vector
        reset = 1'b0;
        tick();
        check("rst2_active", active, 1);
        check("rst2_vld", fetch_valid, 0);
        check("rst2_ia", instr_address, 32'hBFC0_0000);
        reset = 1'b1;
        tick();
        check("rst2_first_pc", fetch_pc, 32'hBFC0_0000);
        check("rst2_first_vld", fetch_valid, 1);

        // Reset while PENDING must discard both held word and pending target
        fetch_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'hBFC0_0400;
        tick();
        check("rstp_hold", fetch_pc, 32'hBFC0_0000);
        redirect_valid = 1'b0; reset = 1'b0;
        tick();
        check("rstp_vld", fetch_valid, 0);
        check("rstp_ia", instr_address, 32'hBFC0_0000);
        reset = 1'b1; fetch_ready = 1'b1;
        exp_q.push_back(32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0004);
        exp_q.push_back(32'hBFC0_0008);
        wait_pc(32'hBFC0_0008);

        // Target with low bits set aligns to 0xFFFFFFFC; pc then wraps to halt
        exp_q.push_back(32'hBFC0_000C);
        exp_q.push_back(32'hFFFF_FFFC);
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
        tick();
        check("wrap_slot", fetch_pc, 32'hBFC0_000C);
        check("wrap_ia0", instr_address, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        tick();
        check("wrap_pc", fetch_pc, 32'hFFFF_FFFC);
        check("wrap_ia1", instr_address, 32'h0000_0000);
        tick();
        check("wrap_vld", fetch_valid, 0);
        check("wrap_active", active, 0);

        @(negedge clk);
        #1;
        check("sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'hBFC00000, SHALL be the first fetch address after reset.
REQ-002 Parameter HALT_ADDR, default 32'h00000000, SHALL be the fetch address that halts the unit.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the reset; it is synchronous and active-low.
REQ-005 instr_address  output  32  SHALL carry the byte address presented to the combinational instruction memory.
REQ-006 instr_readdata  input  32  SHALL carry the instruction word returned combinationally for instr_address.
REQ-007 fetch_valid  output  1  SHALL indicate that fetch_instr and fetch_pc hold an instruction for decode.
REQ-008 fetch_ready  input  1  SHALL indicate that decode accepts the held instruction this cycle.
REQ-009 fetch_instr  output  32  SHALL carry the held instruction word.
REQ-010 fetch_pc  output  32  SHALL carry the byte address of the held instruction.
REQ-011 redirect_valid  input  1  SHALL request a branch or jump to redirect_target.
REQ-012 redirect_target  output-side  input  32  SHALL carry the branch or jump target address.
REQ-013 active  output  1  SHALL be high while not halted.

Function
REQ-014 instr_address SHALL equal the internal pc register, with no combinational path from any input.
REQ-015 A capture SHALL occur when state != HALTED, pc != HALT_ADDR, and (!fetch_valid || fetch_ready).
REQ-016 On a capture: fetch_instr <= instr_readdata, fetch_pc <= pc, fetch_valid <= 1, and pc <= next_pc.
REQ-017 A cycle with fetch_valid && fetch_ready and no capture SHALL clear fetch_valid.
REQ-018 A cycle with fetch_valid && !fetch_ready SHALL hold fetch_instr, fetch_pc and pc unchanged (stall).
REQ-019 FSM states SHALL be RUN, PENDING and HALTED.
REQ-020 In RUN with no redirect, next_pc SHALL be pc + 4, wrapping modulo 2^32.
REQ-021 redirect_valid in RUN with a capture in the same cycle SHALL give next_pc = {redirect_target[31:2], 2'b00}; state stays RUN.
- The instruction captured in that cycle is the delay slot.
REQ-022 redirect_valid in RUN without a capture SHALL latch the aligned target into pending_target and move to PENDING.
REQ-023 In PENDING, the next capture SHALL use next_pc = pending_target and return to RUN.
REQ-024 redirect_valid while in PENDING SHALL be ignored (a branch in a delay slot is unsupported).
REQ-025 When pc == HALT_ADDR in RUN or PENDING, the unit SHALL enter HALTED, drop active on the next edge, and perform no further captures.
REQ-026 In HALTED, an already-held instruction SHALL still complete its handshake normally; fetch_valid then stays 0.
REQ-027 HALTED SHALL be exited only by reset.
REQ-028 redirect_target bits [1:0] SHALL be ignored.

Reset
REQ-029 While reset is low at a rising edge, the unit SHALL set:
- pc = RESET_VECTOR and state = RUN;
- fetch_valid = 0, fetch_instr = 0, fetch_pc = 0;
- pending_target = 0 and active = 1.
REQ-030 Reset asserted mid-stall or in PENDING SHALL discard the held instruction and the pending target.
REQ-031 The first capture SHALL occur in the first cycle with reset high.

Structure
REQ-032 A shared package (mips_pkg) SHALL hold:
- the RESET_VECTOR default;
- the HALT_ADDR default;
- the ifetch_state_t enum {RUN, PENDING, HALTED}.
REQ-033 The output holding register SHALL be a sub-module named ifetch_skid: a one-entry valid/ready register with a capture enable.
REQ-034 The remaining logic (pc, FSM, next_pc mux) SHALL reside in ifetch_unit.

Verification
REQ-035 Reset release with fetch_ready = 1 -> instr_address sequence 0xBFC00000, 0xBFC00004, 0xBFC00008; fetch_pc follows one cycle later; fetch_valid = 1 from the first cycle after release.
REQ-036 fetch_ready = 0 for 3 cycles with fetch_pc = 0xBFC00004 -> fetch_pc, fetch_instr and instr_address remain constant; resume with no lost or duplicated word.
REQ-037 Decode accepts the branch at 0xBFC00010 with redirect_valid = 1 and redirect_target = 0xBFC00103 -> delay slot 0xBFC00014 delivered, then fetch_pc = 0xBFC00100.
REQ-038 redirect_valid during a stall (target 0xBFC00200) -> state PENDING; after fetch_ready, the delay slot is delivered, then 0xBFC00200; a second redirect while PENDING has no effect.
REQ-039 Jump to 0x00000000 (jr r0 convention) -> delay slot delivered, active falls, fetch_valid stays 0; reset low for one cycle restarts at 0xBFC00000.
REQ-040 redirect_target = 0xFFFFFFFC, then sequential fetch -> pc wraps to 0x00000000 and the unit halts.
